// File: rtl/relax_fwdgen.sv
// Bellman-Ford relaxation stage of the forwarding path: computes per-lane candidate distances,
// resolves same-destination conflicts across lanes and tracks per-iteration convergence.
module relax_fwdgen #(
    parameter int unsigned LANES = 4,
    parameter logic [6:0]  INF   = 7'd127,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [28:0]      inp_1,
    input  logic [28:0]      inp_2,
    input  logic [28:0]      inp_3,
    input  logic [28:0]      inp_4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [17:0]      out_1,
    output logic [17:0]      out_2,
    output logic [17:0]      out_3,
    output logic [17:0]      out_4,
    input  logic             iter_start,
    output logic             any_update,
    output logic [CNT_W-1:0] update_count
);

    localparam int unsigned POP_W = $clog2(LANES + 1);

    typedef struct packed {
        logic       up;
        logic [3:0] wij;
        logic [4:0] i;
        logic [4:0] j;
        logic [6:0] wi;
        logic [6:0] wj;
    } edge_wave_t;

    typedef struct packed {
        logic       upd;
        logic [4:0] i;
        logic [4:0] j;
        logic [6:0] cand;
        logic [6:0] wj;
    } relax_t;

    typedef struct packed {
        logic       up;
        logic [4:0] i;
        logic [4:0] j;
        logic [6:0] wj;
    } fwd_wave_t;

    edge_wave_t       in_wave   [LANES];
    logic [7:0]       sum       [LANES];
    logic [6:0]       cand      [LANES];
    relax_t           relax_new [LANES];
    relax_t           s1_q      [LANES];
    relax_t           s1_d      [LANES];
    logic             s1_valid_q, s1_valid_d;
    logic [LANES-1:0] win;
    fwd_wave_t        fwd_new   [LANES];
    fwd_wave_t        out_q     [LANES];
    fwd_wave_t        out_d     [LANES];
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] update_count_q, update_count_d;
    logic             any_update_q, any_update_d;
    logic [CNT_W-1:0] base_count;
    logic [CNT_W:0]   sum_count;
    logic [POP_W-1:0] pop;
    logic             stall;
    logic             xfer;

    assign in_wave[0] = inp_1;
    assign in_wave[1] = inp_2;
    assign in_wave[2] = inp_3;
    assign in_wave[3] = inp_4;

    assign stall     = out_valid_q & ~out_ready;
    assign xfer      = out_valid_q & out_ready;
    assign in_ready  = ~stall;

    // S1: candidate distance saturates to INF so an unreachable source never relaxes anything.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            sum[l] = {1'b0, in_wave[l].wi} + {4'b0000, in_wave[l].wij};
            if (in_wave[l].wi == INF || sum[l] >= {1'b0, INF}) begin
                cand[l] = INF;
            end else begin
                cand[l] = sum[l][6:0];
            end
            relax_new[l].upd  = in_wave[l].up & (cand[l] < in_wave[l].wj);
            relax_new[l].i    = in_wave[l].i;
            relax_new[l].j    = in_wave[l].j;
            relax_new[l].cand = cand[l];
            relax_new[l].wj   = in_wave[l].wj;
        end
    end

    // S2: among updating lanes sharing a destination, only the smallest (cand, lane) survives.
    always_comb begin
        for (int b = 0; b < LANES; b++) begin
            win[b] = s1_q[b].upd;
            for (int a = 0; a < LANES; a++) begin
                if (a != b && s1_q[a].upd && s1_q[a].j == s1_q[b].j &&
                    (s1_q[a].cand < s1_q[b].cand ||
                     (s1_q[a].cand == s1_q[b].cand && a < b))) begin
                    win[b] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            fwd_new[l].up = win[l];
            fwd_new[l].i  = s1_q[l].i;
            fwd_new[l].j  = s1_q[l].j;
            fwd_new[l].wj = win[l] ? s1_q[l].cand : s1_q[l].wj;
        end
    end

    // Both stages advance together; a stalled output freezes the whole pipe.
    always_comb begin
        s1_d        = s1_q;
        s1_valid_d  = s1_valid_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (!stall) begin
            s1_d        = relax_new;
            s1_valid_d  = in_valid;
            out_d       = fwd_new;
            out_valid_d = s1_valid_q;
        end
    end

    always_comb begin
        pop = '0;
        for (int l = 0; l < LANES; l++) begin
            pop = pop + POP_W'(out_q[l].up);
        end
        base_count     = iter_start ? '0 : update_count_q;
        sum_count      = {1'b0, base_count} + (CNT_W + 1)'(pop);
        update_count_d = base_count;
        any_update_d   = any_update_q & ~iter_start;
        // A transfer in the same cycle as iter_start counts toward the new iteration.
        if (xfer) begin
            update_count_d = sum_count[CNT_W] ? '1 : sum_count[CNT_W-1:0];
            any_update_d   = any_update_d | (pop != '0);
        end
    end

    // NOTE: data registers are reset too, because the output wave must read zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q           <= '{default: '0};
            s1_valid_q     <= 1'b0;
            out_q          <= '{default: '0};
            out_valid_q    <= 1'b0;
            update_count_q <= '0;
            any_update_q   <= 1'b0;
        end else begin
            s1_q           <= s1_d;
            s1_valid_q     <= s1_valid_d;
            out_q          <= out_d;
            out_valid_q    <= out_valid_d;
            update_count_q <= update_count_d;
            any_update_q   <= any_update_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_1        = out_q[0];
    assign out_2        = out_q[1];
    assign out_3        = out_q[2];
    assign out_4        = out_q[3];
    assign any_update   = any_update_q;
    assign update_count = update_count_q;

endmodule
